// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: one sum bit per clock, LSB first, with IDLE/SHIFT/DONE control.
// Optional two's-complement overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               done_q;
  logic               accept;
  logic               last_bit;
  logic               s_bit;
  logic               c_next;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Full-adder slice operating on the current LSBs and the running carry.
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shift registers carry no reset: they are reloaded on every accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end else if (state_q == SHIFT) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            carry_q <= cin;
          end
        end
        SHIFT: begin
          cnt_q   <= cnt_q + 1'b1;
          carry_q <= c_next;
          sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
        end
        DONE: begin
          cout_q <= carry_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic cmsb_q;
  logic ovf_q;

  // Carry entering the MSB slice, captured on the final SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if ((state_q == SHIFT) && last_bit) cmsb_q <= carry_q;
      if (state_q == DONE) ovf_q <= cmsb_q ^ carry_q;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: stimulus pushes expected results, a monitor checks each done pulse.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           due;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      check({q[0].name, " missed done"}, 32'(0), 32'(1));
      void'(q.pop_front());
    end
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected done", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, " latency"}, 32'(cyc), 32'(e.due));
        check({e.name, " sum"}, 32'(sum), 32'(e.s));
        check({e.name, " cout"}, 32'(cout), 32'(e.c));
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check({e.name, " ovf"}, 32'(ovf), 32'(e.o));
`endif
      end
    end
  end

  // Called at a negedge before the edge that accepts the start.
  task automatic push(input string name, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es; e.c = ec; e.o = eo; e.name = name;
    e.due = cyc + W + 2;
    q.push_back(e);
  endtask

  task automatic issue(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic [W-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    push(name, es, ec, eo);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      check({name, " timeout"}, 32'(q.size()), 32'(0));
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset sum", 32'(sum), 32'(0));
    check("reset cout", 32'(cout), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First start is set up right after deassertion and must be taken on the next edge.
    a = 8'h5A; b = 8'h25; cin = 1'b0; start = 1'b1;
    push("5A+25", 8'h7F, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    drain("5A+25");

    issue("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); drain("FF+01");
    issue("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0); drain("FF+FF+1");
    issue("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); drain("7F+01");
    issue("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1); drain("80+80");
    issue("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0); drain("00+00+1");
    issue("A5+5A+1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0); drain("A5+5A+1");

    // Start while busy must be ignored.
    issue("10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("10+20");
    check("sum held after ignore", 32'(sum), 32'(8'h30));

    // Reset four cycles into SHIFT abandons the operation.
    issue("abandoned", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("midreset busy", 32'(busy), 32'(0));
    check("midreset sum", 32'(sum), 32'(0));
    check("midreset cout", 32'(cout), 32'(0));
    check("midreset done", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue("post-reset 0F+F0", 8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0); drain("post-reset");

    // start held high: a new operation every W+2 cycles.
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i % (W + 2) == 0) push($sformatf("held #%0d", i / (W + 2)), 8'h78, 1'b0, 1'b0);
      @(negedge clk);
    end
    start = 1'b0;
    drain("held");

    if (q.size() != 0) check("queue empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
